// File: rtl/flag_branch_unit.sv
// Architectural Z/V/N flag register plus a conditional-branch resolver FSM.
// Define FLAG_BYPASS_EN to forward same-cycle ALU flag results into resolution instead of stalling.
module flag_branch_unit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    input  logic       change_z,
    input  logic       change_v,
    input  logic       change_n,
    input  logic       zr,
    input  logic       ov,
    input  logic       neg,
    input  logic       br_req,
    input  logic [2:0] br_cond,
    input  logic       flag_hazard,
    input  logic       flush,
    output logic       br_ack,
    output logic       br_taken,
    output logic       z_flag,
    output logic       v_flag,
    output logic       n_flag
);

    localparam int unsigned CondW = 3;

`ifdef FLAG_BYPASS_EN
    localparam logic BypassEn = 1'b1;
`else
    localparam logic BypassEn = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    state_e state_q;
    logic   z_q, v_q, n_q;
    logic   br_ack_q, br_taken_q;

    logic   wr_z, wr_v, wr_n;
    logic   blocking_wr;
    logic   stall;
    logic   eff_z, eff_v, eff_n;
    logic   cond_met;

    assign wr_z        = alu_valid & change_z;
    assign wr_v        = alu_valid & change_v;
    assign wr_n        = alu_valid & change_n;
    assign blocking_wr = wr_z | wr_v | wr_n;

    // A hazard always stalls; an in-flight flag write stalls only when it cannot be forwarded.
    assign stall = flag_hazard | (blocking_wr & ~BypassEn);

    assign eff_z = (BypassEn & wr_z) ? zr  : z_q;
    assign eff_v = (BypassEn & wr_v) ? ov  : v_q;
    assign eff_n = (BypassEn & wr_n) ? neg : n_q;

    always_comb begin
        cond_met = 1'b0;
        unique case (br_cond)
            CondW'(0): cond_met = ~eff_z;
            CondW'(1): cond_met = eff_z;
            CondW'(2): cond_met = ~eff_z & ~eff_n;
            CondW'(3): cond_met = eff_n;
            CondW'(4): cond_met = eff_z | ~eff_n;
            CondW'(5): cond_met = eff_n | eff_z;
            CondW'(6): cond_met = eff_v;
            CondW'(7): cond_met = 1'b1;
            default:   cond_met = 1'b0;
        endcase
    end

    // Flags update independently; flush does not gate them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_q <= 1'b0;
            v_q <= 1'b0;
            n_q <= 1'b0;
        end else begin
            if (wr_z) z_q <= zr;
            if (wr_v) v_q <= ov;
            if (wr_n) n_q <= neg;
        end
    end

    // IDLE and WAIT share the same transition rules; ACK always returns to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            br_ack_q   <= 1'b0;
            br_taken_q <= 1'b0;
        end else begin
            br_ack_q   <= 1'b0;
            br_taken_q <= 1'b0;
            unique case (state_q)
                ST_IDLE, ST_WAIT: begin
                    if (flush || !br_req) begin
                        state_q <= ST_IDLE;
                    end else if (stall) begin
                        state_q <= ST_WAIT;
                    end else begin
                        state_q    <= ST_ACK;
                        br_ack_q   <= 1'b1;
                        br_taken_q <= cond_met;
                    end
                end
                ST_ACK:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign br_ack   = br_ack_q;
    assign br_taken = br_taken_q;
    assign z_flag   = z_q;
    assign v_flag   = v_q;
    assign n_flag   = n_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed bench for flag_branch_unit: a scoreboard queue of expected br_taken values
// is popped by a monitor on every br_ack; stimulus also checks flags and ack timing.
module tb_flag_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       alu_valid, change_z, change_v, change_n;
    logic       zr, ov, neg;
    logic       br_req;
    logic [2:0] br_cond;
    logic       flag_hazard, flush;
    logic       br_ack, br_taken, z_flag, v_flag, n_flag;

    int checks = 0;
    int errors = 0;
    bit exp_q[$];

`ifdef FLAG_BYPASS_EN
    localparam int WrLat = 1;
`else
    localparam int WrLat = 2;
`endif

    always #5 clk = ~clk;

    flag_branch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alu_valid   (alu_valid),
        .change_z    (change_z),
        .change_v    (change_v),
        .change_n    (change_n),
        .zr          (zr),
        .ov          (ov),
        .neg         (neg),
        .br_req      (br_req),
        .br_cond     (br_cond),
        .flag_hazard (flag_hazard),
        .flush       (flush),
        .br_ack      (br_ack),
        .br_taken    (br_taken),
        .z_flag      (z_flag),
        .v_flag      (v_flag),
        .n_flag      (n_flag)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every ack must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && br_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got br_ack=1 expected no ack (taken=%b)", br_taken);
            end else begin
                chk("br_taken", br_taken, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_alu();
        alu_valid = 1'b0;
        change_z  = 1'b0;
        change_v  = 1'b0;
        change_n  = 1'b0;
    endtask

    task automatic write_flags(input logic vz, input logic vv, input logic vn,
                               input logic cz, input logic cv, input logic cn);
        alu_valid = 1'b1;
        change_z  = cz;
        change_v  = cv;
        change_n  = cn;
        zr        = vz;
        ov        = vv;
        neg       = vn;
        step();
        clear_alu();
    endtask

    // Raise br_req, expect the ack exp_lat cycles later, then leave one idle cycle.
    task automatic request(input string name, input logic [2:0] cond,
                           input bit exp_taken, input int exp_lat);
        int lat;
        lat = 0;
        br_req  = 1'b1;
        br_cond = cond;
        exp_q.push_back(exp_taken);
        for (int i = 1; i <= 10; i++) begin
            step();
            clear_alu();
            if (br_ack === 1'b1) begin
                lat = i;
                break;
            end
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d (0 = no ack)", name, lat, exp_lat);
        end
        br_req = 1'b0;
        step();
    endtask

    initial begin
        rst_n       = 1'b0;
        alu_valid   = 1'b0;
        change_z    = 1'b0;
        change_v    = 1'b0;
        change_n    = 1'b0;
        zr          = 1'b0;
        ov          = 1'b0;
        neg         = 1'b0;
        br_req      = 1'b0;
        br_cond     = 3'b000;
        flag_hazard = 1'b0;
        flush       = 1'b0;

        #2;
        chk("rst_z", z_flag, 1'b0);
        chk("rst_v", v_flag, 1'b0);
        chk("rst_n_flag", n_flag, 1'b0);
        chk("rst_ack", br_ack, 1'b0);
        chk("rst_taken", br_taken, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Selective flag write, then change_* without alu_valid
        alu_valid = 1'b1; change_z = 1'b1; zr = 1'b1; change_n = 1'b0; neg = 1'b1;
        step();
        clear_alu();
        chk("wr_z", z_flag, 1'b1);
        chk("wr_n_hold", n_flag, 1'b0);
        chk("wr_v_hold", v_flag, 1'b0);
        alu_valid = 1'b0; change_z = 1'b1; zr = 1'b0; change_n = 1'b1; neg = 1'b1;
        step();
        clear_alu();
        chk("novalid_z", z_flag, 1'b1);
        chk("novalid_n", n_flag, 1'b0);

        write_flags(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("clr_z", z_flag, 1'b0);
        request("c010_all0", 3'b010, 1'b1, 1);
        request("c110_all0", 3'b110, 1'b0, 1);

        // Z=1 N=0 V=0
        write_flags(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        request("c000_z1", 3'b000, 1'b0, 1);
        request("c001_z1", 3'b001, 1'b1, 1);
        request("c100_z1", 3'b100, 1'b1, 1);
        request("c101_z1", 3'b101, 1'b1, 1);
        request("c011_z1", 3'b011, 1'b0, 1);
        request("c111_z1", 3'b111, 1'b1, 1);

        // Z=0 V=1 N=1
        write_flags(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        request("c010_vn", 3'b010, 1'b0, 1);
        request("c011_vn", 3'b011, 1'b1, 1);
        request("c100_vn", 3'b100, 1'b0, 1);
        request("c110_vn", 3'b110, 1'b1, 1);
        request("c101_vn", 3'b101, 1'b1, 1);

        write_flags(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("vonly_z", z_flag, 1'b0);
        chk("vonly_v", v_flag, 1'b0);
        chk("vonly_n", n_flag, 1'b1);

        // Hazard held three cycles blocks the ack
        br_req = 1'b1; br_cond = 3'b111; flag_hazard = 1'b1;
        exp_q.push_back(1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hazard_noack", br_ack, 1'b0);
        end
        flag_hazard = 1'b0;
        step();
        chk("hazard_ack", br_ack, 1'b1);
        br_req = 1'b0;
        step();
        chk("hazard_after", br_ack, 1'b0);

        // Same-cycle flag write: forwarded or stalled a cycle
        alu_valid = 1'b1; change_z = 1'b1; zr = 1'b1;
        request("c001_wr", 3'b001, 1'b1, WrLat);
        chk("wr_z_after", z_flag, 1'b1);
        alu_valid = 1'b1; change_z = 1'b1; zr = 1'b0;
        request("c000_wr", 3'b000, 1'b1, WrLat);

        // Flush in IDLE
        br_req = 1'b1; br_cond = 3'b111; flush = 1'b1;
        step();
        chk("flush_idle_noack", br_ack, 1'b0);
        br_req = 1'b0; flush = 1'b0;
        step();
        chk("flush_idle_noack2", br_ack, 1'b0);

        // Flush in WAIT alongside a flag write
        br_req = 1'b1; br_cond = 3'b111; flag_hazard = 1'b1;
        step();
        chk("wait_noack", br_ack, 1'b0);
        flush = 1'b1; flag_hazard = 1'b0;
        alu_valid = 1'b1; change_n = 1'b1; neg = 1'b0;
        step();
        clear_alu();
        flush = 1'b0; br_req = 1'b0;
        chk("flush_wait_noack", br_ack, 1'b0);
        chk("flush_wait_n", n_flag, 1'b0);
        step();
        chk("flush_wait_noack2", br_ack, 1'b0);

        // Asynchronous reset mid-WAIT with all flags set
        write_flags(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("all1_z", z_flag, 1'b1);
        br_req = 1'b1; br_cond = 3'b111; flag_hazard = 1'b1;
        step();
        chk("prerst_noack", br_ack, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_z", z_flag, 1'b0);
        chk("arst_v", v_flag, 1'b0);
        chk("arst_n", n_flag, 1'b0);
        chk("arst_ack", br_ack, 1'b0);
        br_req = 1'b0; flag_hazard = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        chk("postrst_noack", br_ack, 1'b0);
        step();
        chk("postrst_noack2", br_ack, 1'b0);
        request("c111_postrst", 3'b111, 1'b1, 1);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
